mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
Iterative multiply/divide sequencer for the RV32M instructions occupying the execute stage. When an M-op is present in EX, it stalls the front of the pipeline and runs a shift-add multiply or a restoring divide for XLEN cycles. It then presents a one-cycle result to the EX/MEM boundary alongside the ALU result path. It owns a private 2·XLEN accumulator, so the main ALU stays free of multi-cycle logic.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start_E  input  1  valid M-extension op in EX (decoded, not flushed)
funct3_E  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
srcA_E  input  XLEN  rs1 value after forwarding
srcB_E  input  XLEN  rs2 value after forwarding
flush_E  input  1  kill the EX instruction (branch taken / trap)
stall_E  output  1  hold PC, IF/ID and ID/EX registers
done_E  output  1  result valid this cycle, one-cycle pulse
mdu_result_E  output  XLEN  result; muxed over the ALU result when done_E=1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, accumulator=0.
  - stall_E=0, done_E=0, mdu_result_E=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - stall_E = start_E & ~flush_E (combinational).
  - On a clock edge with start_E=1 and flush_E=0:
    - Latch funct3 and the operand signs.
    - Load the magnitude operands (signed ops take two's-complement absolute values; MULHSU treats srcB as unsigned).
    - counter=XLEN; go to RUN.
- RUN:
  - stall_E=1.
  - Multiply: one shift-add step per cycle on the {hi,lo} accumulator.
  - Divide: one restoring step per cycle (shift remainder/quotient, trial subtract, keep if non-negative).
  - counter decrements each cycle; at counter==1 go to DONE. Exactly XLEN RUN cycles.
- DONE:
  - stall_E=0, done_E=1, mdu_result_E valid.
  - Next state is IDLE unconditionally. start_E is ignored in DONE; the pipeline advances at this edge.
- Latency: start accepted in cycle T; done_E=1 in cycle T+XLEN+1. stall_E is high in cycles T..T+XLEN.
- Result selection and sign fix-up (applied on entry to DONE, result registered):
  - MUL: low XLEN of the product. MULH/MULHSU/MULHU: high XLEN.
  - The product is negated (2·XLEN wide) when the operand signs differ (signed forms only).
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Signed divide: quotient negated if the signs differ; remainder takes the sign of srcA.
- Divide by zero (srcB==0):
  - Quotient = all ones for both DIV and DIVU.
  - Remainder = srcA unchanged; no sign fix-up.
- Signed overflow (DIV of 0x80000000 by −1):
  - Quotient = 0x80000000, remainder = 0.
  - No exception is raised.
- mdu_result_E holds its last value outside DONE; consumers qualify it with done_E.
- flush_E=1 in RUN: next state IDLE, done_E never pulses, accumulator contents are don't-care. flush_E=1 in DONE: done_E still pulses; the pipeline discards it.
- Async reset mid-RUN: all outputs drop to 0 immediately; operation abandoned.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined:
  - Divide-by-zero and multiply with either operand zero skip RUN and go IDLE→DONE, giving done_E in cycle T+1.
  - stall_E is high only in cycle T.
  - Results are identical to the full-length path.
- Undefined: every operation takes the full XLEN+1-cycle latency; no operand-zero detection logic is present.

Test Plan:
- MUL srcA=7, srcB=0xFFFFFFFD (−3), start at cycle T:
  - Required: stall_E high T..T+32; done_E only at T+33; mdu_result_E=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Back-to-back: second start_E held high through DONE.
  - Required: second op accepted the cycle after DONE; two done_E pulses 34 cycles apart.
- flush_E asserted in the 10th RUN cycle → IDLE next cycle, stall_E=0, no done_E. Separately, rst pulled low mid-RUN → outputs 0 immediately.
  - With MDU_EARLY_OUT_EN: DIV x/0 → done_E at T+1.

Source files
------------

// File: rtl/mdu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer_if
// Purpose  : EX-stage handshake bundle between the pipeline and the iterative
//            multiply/divide sequencer.
// Ports    : (interface signals)
//   start_E      valid M-extension op in EX (pipeline -> MDU)
//   funct3_E     M-op selector (pipeline -> MDU)
//   srcA_E       rs1 value after forwarding (pipeline -> MDU)
//   srcB_E       rs2 value after forwarding (pipeline -> MDU)
//   flush_E      kill the EX instruction (pipeline -> MDU)
//   stall_E      hold PC, IF/ID and ID/EX (MDU -> pipeline)
//   done_E       one-cycle result-valid pulse (MDU -> pipeline)
//   mdu_result_E result, qualified by done_E (MDU -> pipeline)
// Revision : 1.0 - initial release
// ============================================================================
interface mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_E;
  logic [2:0]      funct3_E;
  logic [XLEN-1:0] srcA_E;
  logic [XLEN-1:0] srcB_E;
  logic            flush_E;
  logic            stall_E;
  logic            done_E;
  logic [XLEN-1:0] mdu_result_E;

  modport master (
    output start_E, funct3_E, srcA_E, srcB_E, flush_E,
    input  stall_E, done_E, mdu_result_E
  );

  modport slave (
    input  start_E, funct3_E, srcA_E, srcB_E, flush_E,
    output stall_E, done_E, mdu_result_E
  );
endinterface
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            Shift-add multiply or restoring divide, one step per cycle for
//            XLEN cycles, then a one-cycle registered result with done_E.
// Ports    :
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - mdu_sequencer_if.slave (start/funct3/operands/flush in,
//          stall/done/result out)
// Options  : MDU_EARLY_OUT_EN - divide by zero and multiply by zero skip the
//            iteration phase and finish one cycle after acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mdu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;      // multiply: {hi,lo}; divide: {remainder,quotient}
  logic [XLEN-1:0]   opb;      // multiplicand / divisor magnitude
  logic [2:0]        op;
  logic              neg_q;    // operand signs differ (product / quotient negate)
  logic              neg_r;    // dividend negative (remainder negate)
  logic              b_zero;
  logic [XLEN-1:0]   result;

  logic              accept;
  logic              stall;
  logic              done;
  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin;

  assign accept = (state == IDLE) && bus.start_E && !bus.flush_E;

  // Operand signedness and magnitudes. MUL only needs the low half, which is
  // sign-agnostic, so it is run unsigned.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (bus.funct3_E)
      3'd1, 3'd4, 3'd6: begin
        sgn_a = bus.srcA_E[XLEN-1];
        sgn_b = bus.srcB_E[XLEN-1];
      end
      3'd2:    sgn_a = bus.srcA_E[XLEN-1];
      default: ;
    endcase
    mag_a = sgn_a ? -bus.srcA_E : bus.srcA_E;
    mag_b = sgn_b ? -bus.srcB_E : bus.srcB_E;
  end

`ifdef MDU_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_res;

  always_comb begin
    if (bus.funct3_E[2]) begin
      early     = (bus.srcB_E == '0);
      early_res = bus.funct3_E[1] ? bus.srcA_E : '1;
    end else begin
      early     = (bus.srcA_E == '0) || (bus.srcB_E == '0);
      early_res = '0;
    end
  end
`endif

  // One iteration step and the sign fix-up of the final step's value.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opb};
    if (op[2]) begin
      if (!div_diff[XLEN])
        acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end

    prod = neg_q ? -acc_step : acc_step;
    // A zero divisor yields an all-ones quotient pattern that must not be
    // sign-corrected; the remainder (|srcA| with srcA's sign) is srcA itself.
    if (b_zero)
      quo_fix = '1;
    else
      quo_fix = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    case (op)
      3'd0:             fin = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fin = quo_fix;
      default:          fin = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so stall stays low while reset is held.
        stall = bus.start_E & ~bus.flush_E & rst;
        if (accept) begin
`ifdef MDU_EARLY_OUT_EN
          state_nxt = early ? DONE : RUN;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN: begin
        stall = 1'b1;
        if (bus.flush_E)                state_nxt = IDLE;
        else if (cnt == CNT_W'(1))      state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op     <= bus.funct3_E;
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            b_zero <= (bus.srcB_E == '0);
            opb    <= mag_b;
            acc    <= {{XLEN{1'b0}}, mag_a};
            cnt    <= CNT_W'(XLEN);
`ifdef MDU_EARLY_OUT_EN
            if (early) result <= early_res;
`endif
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1) && !bus.flush_E) result <= fin;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_E      = stall;
  assign bus.done_E       = done;
  assign bus.mdu_result_E = result;

endmodule
`default_nettype wire
